// File: rtl/fft_seq_ctrl.sv
// Sequencer for one 2^N_LOG2-point radix-2 DIT FFT frame: bit-reversed load, staged butterfly
// issue over valid/ready with an outstanding-request limit, then natural-order unload.
module fft_seq_ctrl #(
  parameter int N_LOG2    = 9,
  parameter int RAM_LAT   = 1,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_async,
  output logic [N_LOG2-1:0] in_addr,
  output logic              load_we,
  output logic [N_LOG2-1:0] load_addr,
  output logic              bfly_valid,
  input  logic              bfly_ready,
  output logic [N_LOG2-1:0] bfly_addr_a,
  output logic [N_LOG2-1:0] bfly_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  input  logic              bfly_done,
  output logic [N_LOG2-1:0] out_rd_addr,
  output logic              out_we,
  output logic [N_LOG2-1:0] out_wr_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int N  = 1 << N_LOG2;
  localparam int CW = $clog2(N + RAM_LAT) + 1;
  localparam int SW = $clog2(N_LOG2 + 1);
  localparam int BW = N_LOG2 - 1;
  localparam int OW = (BW > $clog2(MAX_OUTST + 1)) ? BW : $clog2(MAX_OUTST + 1);

  localparam logic [CW-1:0]     XFER_LAST = CW'(N + RAM_LAT - 1);
  localparam logic [CW-1:0]     N_CNT     = CW'(N);
  localparam logic [BW-1:0]     B_LAST    = BW'((N / 2) - 1);
  localparam logic [SW-1:0]     S_LAST    = SW'(N_LOG2 - 1);
  localparam logic [OW-1:0]     OUTST_MAX = OW'(MAX_OUTST);
  localparam logic [N_LOG2-1:0] A_ZERO    = N_LOG2'(0);
  localparam logic [BW-1:0]     B_ZERO    = BW'(0);
  localparam logic [SW-1:0]     S_ZERO    = SW'(0);
  localparam logic [OW-1:0]     O_ZERO    = OW'(0);
  localparam logic [CW-1:0]     C_ZERO    = CW'(0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STAGE  = 3'd2,
    DRAIN  = 3'd3,
    UNLOAD = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic [SW-1:0]     s;
  logic [SW-1:0]     s_inc;
  logic [BW-1:0]     b;
  logic [BW-1:0]     b_inc;
  logic [OW-1:0]     outst;
  logic [OW-1:0]     outst_nxt;
  logic              hs;
  logic              valid_ok;
  logic              spurious_done;
  logic              sync1, sync2, sync3;
  logic              start_edge;
  logic              load_src;
  logic              unload_src;
  logic [RAM_LAT-1:0] ld_v;
  logic [RAM_LAT-1:0] ul_v;
  logic [N_LOG2-1:0] ld_a [RAM_LAT];
  logic [N_LOG2-1:0] ul_a [RAM_LAT];

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int k = 0; k < N_LOG2; k++) r[k] = v[N_LOG2-1-k];
    return r;
  endfunction

  function automatic logic [N_LOG2-1:0] pos_of(input logic [BW-1:0] bb, input logic [SW-1:0] ss);
    logic [N_LOG2-1:0] mask;
    mask = (N_LOG2'(1) << ss) - N_LOG2'(1);
    return {1'b0, bb} & mask;
  endfunction

  function automatic logic [N_LOG2-1:0] calc_a(input logic [BW-1:0] bb, input logic [SW-1:0] ss);
    logic [N_LOG2-1:0] bw;
    bw = {1'b0, bb};
    return ((bw >> ss) << (ss + SW'(1))) | pos_of(bb, ss);
  endfunction

  function automatic logic [N_LOG2-1:0] calc_b(input logic [BW-1:0] bb, input logic [SW-1:0] ss);
    return calc_a(bb, ss) + (N_LOG2'(1) << ss);
  endfunction

  function automatic logic [N_LOG2-2:0] calc_tw(input logic [BW-1:0] bb, input logic [SW-1:0] ss);
    logic [N_LOG2-1:0] t;
    t = pos_of(bb, ss) << (SW'(N_LOG2 - 1) - ss);
    return t[N_LOG2-2:0];
  endfunction

  assign start_edge = sync2 & ~sync3;
  assign load_we    = ld_v[RAM_LAT-1];
  assign load_addr  = ld_a[RAM_LAT-1];
  assign out_we     = ul_v[RAM_LAT-1];
  assign out_wr_addr = ul_a[RAM_LAT-1];

  // Start flag crosses from the sck domain through two flops plus an edge-detect flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= start_async;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Handshake, outstanding-count update and counter increments
  always_comb begin
    hs        = bfly_valid & bfly_ready;
    cnt_inc   = cnt + CW'(1);
    s_inc     = s + SW'(1);
    b_inc     = b + BW'(1);
    load_src  = (state == LOAD) && (cnt < N_CNT);
    unload_src = (state == UNLOAD) && (cnt < N_CNT);
    case ({hs, bfly_done})
      2'b10:   outst_nxt = outst + OW'(1);
      2'b01:   outst_nxt = (outst == O_ZERO) ? O_ZERO : outst - OW'(1);
      default: outst_nxt = outst;
    endcase
    valid_ok = outst_nxt < OUTST_MAX;
    // a done that outlived a mid-frame reset lands in IDLE and is not an error
    spurious_done = bfly_done && !hs && (outst == O_ZERO) && (state != IDLE);
  end

  // RAM read-latency pipelines for the load and unload write ports
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_v <= RAM_LAT'(0);
      ul_v <= RAM_LAT'(0);
      for (int k = 0; k < RAM_LAT; k++) begin
        ld_a[k] <= A_ZERO;
        ul_a[k] <= A_ZERO;
      end
    end else begin
      ld_v[0] <= load_src;
      ld_a[0] <= load_src ? bitrev(in_addr) : A_ZERO;
      ul_v[0] <= unload_src;
      ul_a[0] <= unload_src ? out_rd_addr : A_ZERO;
      for (int k = 1; k < RAM_LAT; k++) begin
        ld_v[k] <= ld_v[k-1];
        ld_a[k] <= ld_a[k-1];
        ul_v[k] <= ul_v[k-1];
        ul_a[k] <= ul_a[k-1];
      end
    end
  end

  // Frame sequencer with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= C_ZERO;
      s           <= S_ZERO;
      b           <= B_ZERO;
      outst       <= O_ZERO;
      in_addr     <= A_ZERO;
      out_rd_addr <= A_ZERO;
      bfly_valid  <= 1'b0;
      bfly_addr_a <= A_ZERO;
      bfly_addr_b <= A_ZERO;
      tw_addr     <= BW'(0);
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      outst <= outst_nxt;
      if ((start_edge && (state != IDLE)) || spurious_done) err <= 1'b1;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state   <= LOAD;
            busy    <= 1'b1;
            cnt     <= C_ZERO;
            in_addr <= A_ZERO;
          end
        end
        LOAD: begin
          cnt     <= cnt_inc;
          in_addr <= (cnt_inc < N_CNT) ? cnt_inc[N_LOG2-1:0] : A_ZERO;
          if (cnt == XFER_LAST) begin
            state       <= STAGE;
            cnt         <= C_ZERO;
            s           <= S_ZERO;
            b           <= B_ZERO;
            bfly_valid  <= valid_ok;
            bfly_addr_a <= calc_a(B_ZERO, S_ZERO);
            bfly_addr_b <= calc_b(B_ZERO, S_ZERO);
            tw_addr     <= calc_tw(B_ZERO, S_ZERO);
          end
        end
        STAGE: begin
          if (hs) begin
            if (b == B_LAST) begin
              state       <= DRAIN;
              bfly_valid  <= 1'b0;
              bfly_addr_a <= A_ZERO;
              bfly_addr_b <= A_ZERO;
              tw_addr     <= BW'(0);
            end else begin
              b           <= b_inc;
              bfly_valid  <= valid_ok;
              bfly_addr_a <= calc_a(b_inc, s);
              bfly_addr_b <= calc_b(b_inc, s);
              tw_addr     <= calc_tw(b_inc, s);
            end
          end else begin
            bfly_valid <= valid_ok;
          end
        end
        DRAIN: begin
          // stage barrier: next stage reads what this stage wrote
          if (outst == O_ZERO) begin
            if (s == S_LAST) begin
              state       <= UNLOAD;
              cnt         <= C_ZERO;
              out_rd_addr <= A_ZERO;
            end else begin
              state       <= STAGE;
              s           <= s_inc;
              b           <= B_ZERO;
              bfly_valid  <= valid_ok;
              bfly_addr_a <= calc_a(B_ZERO, s_inc);
              bfly_addr_b <= calc_b(B_ZERO, s_inc);
              tw_addr     <= calc_tw(B_ZERO, s_inc);
            end
          end
        end
        UNLOAD: begin
          cnt         <= cnt_inc;
          out_rd_addr <= (cnt_inc < N_CNT) ? cnt_inc[N_LOG2-1:0] : A_ZERO;
          if (cnt == XFER_LAST) begin
            state <= DONE;
            cnt   <= C_ZERO;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          bfly_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
